// File: rtl/fifo_buffer_ext_if.sv
// Bundle of FIFO control, data and status signals.
// master: client side driving requests; slave: FIFO side.
interface fifo_buffer_ext_if #(
  parameter int D_BITS    = 8,
  parameter int ADDR_BITS = 3
);
  logic              flush;
  logic              clr_err;
  logic [D_BITS-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [D_BITS-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_BITS:0] level;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, clr_err, din, wr_en, rd_en,
    input  dout, dout_valid, full, empty,
    input  almost_full, almost_empty, level,
    input  overflow, underflow
  );

  modport slave (
    input  flush, clr_err, din, wr_en, rd_en,
    output dout, dout_valid, full, empty,
    output almost_full, almost_empty, level,
    output overflow, underflow
  );
endinterface

// File: rtl/fifo_buffer_ext.sv
// Parametrised synchronous FIFO with standard or FWFT read mode.
// Ports: clk, reset_n (async low), bus (slave side of fifo_buffer_ext_if).
module fifo_buffer_ext #(
  parameter int D_BITS    = 8,
  parameter int ADDR_BITS = 3,
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = 6,
  parameter int AE_LEVEL  = 1
) (
  input logic              clk,
  input logic              reset_n,
  fifo_buffer_ext_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int LW = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0] DEPTH_L = LW'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_L = LW'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_L = LW'(AE_LEVEL);

  logic [D_BITS-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   level;
  logic                 full;
  logic                 empty;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 wr_err;
  logic                 rd_err;
  logic                 ovf;
  logic                 udf;

  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  // flush overrides any request in the same cycle
  assign wr_acc = bus.wr_en & ~full & ~bus.flush;
  assign rd_acc = bus.rd_en & ~empty & ~bus.flush;
  assign wr_err = bus.wr_en & full & ~bus.flush;
  assign rd_err = bus.rd_en & empty & ~bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc & ~rd_acc)
        level <= level + 1'b1;
      else if (rd_acc & ~wr_acc)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.din;
  end

  // a new error in the clearing cycle still sets the flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= wr_err | (ovf & ~bus.clr_err);
      udf <= rd_err | (udf & ~bus.clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout = empty ? '0 : mem[rd_ptr];
      assign bus.dout_valid = ~empty;
    end else begin : g_std
      logic [D_BITS-1:0] dout_q;
      logic              dv_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dv_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr];
        end
      end
      assign bus.dout = dout_q;
      assign bus.dout_valid = dv_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level >= AF_L);
  assign bus.almost_empty = (level <= AE_L);
  assign bus.level        = level;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule

// File: doc/fifo_buffer_ext.md
Name: fifo_buffer_ext

Overview:
Parametrised synchronous FIFO, successor to the fixed 8-entry UART FIFO. Sits between the UART RX/TX cores and slower or faster client logic. Adds:
- power-of-two depth set by address width;
- concurrent read and write;
- selectable standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full/almost-empty thresholds;
- fill level output;
- synchronous flush;
- sticky overflow/underflow error flags.

Parameters:
D_BITS, 8, data word width.
ADDR_BITS, 3, pointer width; DEPTH = 2**ADDR_BITS entries.
FWFT, 0, read mode: 0 = standard (registered dout, 1-cycle latency); 1 = first-word-fall-through.
AF_LEVEL, 6, almost_full asserts when level >= AF_LEVEL (range 1..DEPTH).
AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL (range 0..DEPTH-1).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of FIFO contents.
clr_err  in  1  synchronous clear of overflow/underflow.
din  in  D_BITS  write data.
wr_en  in  1  write request.
rd_en  in  1  read request (FWFT: acknowledge/pop of head word).
dout  out  D_BITS  read data.
dout_valid  out  1  dout holds a valid popped/head word.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
almost_full  out  1  level >= AF_LEVEL.
almost_empty  out  1  level <= AE_LEVEL.
level  out  ADDR_BITS+1  current occupancy 0..DEPTH.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
Reset (reset_n low, asynchronous):
- wr_ptr, rd_ptr, level, dout, dout_valid, overflow, underflow = 0.
- empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- Memory array is not reset.
- Reset asserted mid-operation discards all contents immediately.

Pointers and level:
- Pointers are ADDR_BITS wide and wrap DEPTH-1 -> 0 by natural overflow.
- level is ADDR_BITS+1 wide.

Accept rules:
- wr_acc = wr_en & ~full.
- rd_acc = rd_en & ~empty.
- Both are evaluated on registered state of the current cycle.
- wr_acc: mem[wr_ptr] <= din; wr_ptr increments.
- rd_acc: rd_ptr increments.

Level update:
- +1 on wr_acc only.
- -1 on rd_acc only.
- Unchanged when both or neither are accepted.

Boundary cases:
- Full with wr_en & rd_en: read accepted, write rejected, overflow set; level becomes DEPTH-1.
- Empty with wr_en & rd_en: write accepted, read rejected, underflow set; level becomes 1.

Status outputs:
- full, empty, almost_full, almost_empty are combinational decodes of the registered level.
- They change in the cycle after the causing edge.

Error flags:
- overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty.
- Both are cleared by clr_err.
- If clr_err coincides with a new error event, the set wins.

Flush:
- Highest synchronous priority.
- Clears pointers, level, and dout_valid; dout holds its last value.
- wr_en/rd_en in the same cycle are ignored.
- Error flags are unaffected.

FWFT=0 (standard mode):
- On rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1 at the next edge (latency 1).
- Otherwise dout holds its value and dout_valid <= 0 (single-cycle pulse per pop).

FWFT=1:
- dout = mem[rd_ptr] combinationally while ~empty; dout = 0 when empty.
- dout_valid = ~empty.
- rd_acc consumes the presented word; the next word (or 0) is shown after the edge.
- A word written into an empty FIFO appears on dout the cycle after its write edge.

Memory read/write coincidence:
- Same-address read and write cannot occur on an accepted pair except when level == 0 (read rejected) or level == DEPTH (write rejected).
- No bypass logic is required.

Test Plan:
- Reset then fill: 8 writes of 0x11..0x88 -> after the 8th edge, level=8, full=1, almost_full=1 (from level 6 onward); 9th write -> overflow=1, level stays 8, contents unchanged.
- Drain, FWFT=0: 8 reads after fill -> dout = 0x11..0x88, each one cycle after its rd_en with a dout_valid pulse; then empty=1; extra read -> underflow=1, dout stays 0x88.
- Wrap-around: write 5, read 5, write 6, read 6 -> data order preserved across pointer wrap; level returns to 0; no error flags set.
- Simultaneous: level=4 with wr_en & rd_en for 10 cycles -> level constant 4, output stream in order. At full, wr&rd -> level=7, overflow=1. At empty, wr&rd -> level=1, underflow=1.
- FWFT=1: write 0xA5 into empty -> next cycle dout=0xA5, dout_valid=1. rd_en -> dout=0, dout_valid=0. clr_err clears sticky flags set earlier.
- Flush and reset mid-operation: level=5 with flush & wr_en -> level=0, empty=1, write ignored, errors retained. Async reset_n pulse between edges -> all outputs at reset values immediately.
